// File: rtl/mrram_wr_arb.sv
// ============================================================================
//  Module   : mrram_wr_arb
//  Function : Round-robin write-port arbiter for a multi-read-port register file
//  Revision : 1.0
// ============================================================================
`default_nettype none

module mrram_wr_arb #(
  parameter int MEMD  = 16,
  parameter int DATAW = 32,
  parameter int nWREQ = 4,
  localparam int ADDRW = (MEMD > 1) ? $clog2(MEMD) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     hold,
  input  logic [nWREQ-1:0]         req_valid,
  input  logic [nWREQ*ADDRW-1:0]   req_addr,
  input  logic [nWREQ*DATAW-1:0]   req_data,
  output logic [nWREQ-1:0]         req_ready,
  output logic                     WEnb,
  output logic [ADDRW-1:0]         WAddr,
  output logic [DATAW-1:0]         WData,
  output logic [15:0]              wait_cnt
);

  localparam int             PTRW   = $clog2(nWREQ);
  localparam logic [PTRW:0]  NREQ_W = (PTRW+1)'(nWREQ);
  localparam logic [PTRW:0]  ONE_W  = (PTRW+1)'(1);

  logic [PTRW-1:0]  ptr_q;
  logic [PTRW-1:0]  ptr_d;
  logic             wen_q;
  logic [ADDRW-1:0] waddr_q;
  logic [DATAW-1:0] wdata_q;
  logic [15:0]      wait_cnt_q;

  logic             gnt_found;
  logic [PTRW-1:0]  gnt_idx;
  logic             xfer;
  logic [ADDRW-1:0] sel_addr;
  logic [DATAW-1:0] sel_data;
  logic [PTRW:0]    ptr_inc;

  // Rotating search starting at ptr_q; first valid requester wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < nWREQ; k++) begin
      logic [PTRW:0] s;
      s = {1'b0, ptr_q} + k[PTRW:0];
      if (s >= NREQ_W) s = s - NREQ_W;
      if (!gnt_found && req_valid[s[PTRW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = s[PTRW-1:0];
      end
    end
    if (hold || rst) gnt_found = 1'b0;
  end

  always_comb begin
    req_ready = '0;
    if (gnt_found) req_ready[gnt_idx] = 1'b1;
  end

  assign xfer = gnt_found;

  // Grant is one-hot, so an OR-reduction mux selects the winning slices.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < nWREQ; i++) begin
      if (req_ready[i]) begin
        sel_addr = sel_addr | req_addr[i*ADDRW +: ADDRW];
        sel_data = sel_data | req_data[i*DATAW +: DATAW];
      end
    end
  end

  always_comb begin
    ptr_inc = {1'b0, gnt_idx} + ONE_W;
    ptr_d   = ptr_q;
    if (xfer) ptr_d = (ptr_inc == NREQ_W) ? '0 : ptr_inc[PTRW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      wen_q      <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      wait_cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      wen_q <= xfer;
      if (xfer) begin
        waddr_q <= sel_addr;
        wdata_q <= sel_data;
      end
      // Contention is counted even while hold blocks grants.
      if (($countones(req_valid) >= 2) && (wait_cnt_q != 16'hFFFF))
        wait_cnt_q <= wait_cnt_q + 16'd1;
    end
  end

  assign WEnb     = wen_q;
  assign WAddr    = waddr_q;
  assign WData    = wdata_q;
  assign wait_cnt = wait_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_mrram_wr_arb.sv
// ============================================================================
//  Module   : tb_mrram_wr_arb
//  Function : Directed-vector self-checking bench for mrram_wr_arb
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mrram_wr_arb;

  localparam int MEMD  = 16;
  localparam int DATAW = 32;
  localparam int NW    = 4;
  localparam int ADDRW = 4;

  logic                 clk;
  logic                 rst;
  logic                 hold;
  logic [NW-1:0]        req_valid;
  logic [NW*ADDRW-1:0]  req_addr;
  logic [NW*DATAW-1:0]  req_data;
  logic [NW-1:0]        req_ready;
  logic                 WEnb;
  logic [ADDRW-1:0]     WAddr;
  logic [DATAW-1:0]     WData;
  logic [15:0]          wait_cnt;

  int vec_cnt;
  int err_cnt;

  mrram_wr_arb #(.MEMD(MEMD), .DATAW(DATAW), .nWREQ(NW)) dut (
    .clk       (clk),
    .rst       (rst),
    .hold      (hold),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .WEnb      (WEnb),
    .WAddr     (WAddr),
    .WData     (WData),
    .wait_cnt  (wait_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    vec_cnt   = 0;
    err_cnt   = 0;
    rst       = 1'b1;
    hold      = 1'b0;
    req_valid = '0;
    for (int i = 0; i < NW; i++) begin
      req_addr[i*ADDRW +: ADDRW] = ADDRW'(i);
      req_data[i*DATAW +: DATAW] = 32'hA0 + 32'(i);
    end

    // Reset state; grants suppressed while rst is high
    tick();
    tick();
    req_valid = 4'b1111;
    #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_wenb",  32'(WEnb),      32'h0);
    chk("rst_waddr", 32'(WAddr),     32'h0);
    chk("rst_wdata", WData,          32'h0);
    chk("rst_wcnt",  32'(wait_cnt),  32'h0);
    req_valid = '0;
    tick();
    rst = 1'b0;
    #1;

    // All four requesting: grants 0,1,2,3 in order
    req_valid = 4'b1111;
    #1;
    chk("rr_ready0", 32'(req_ready), 32'h1);
    for (int g = 0; g < NW; g++) begin
      tick();
      chk("rr_wenb",  32'(WEnb),  32'h1);
      chk("rr_waddr", 32'(WAddr), 32'(g));
      chk("rr_wdata", WData,      32'hA0 + 32'(g));
      if (g < NW-1) chk("rr_ready", 32'(req_ready), 32'h1 << (g+1));
    end
    chk("rr_wcnt", 32'(wait_cnt), 32'd4);
    req_valid = '0;
    #1;

    // Single requester 2
    req_valid = 4'b0100;
    #1;
    chk("single_ready", 32'(req_ready), 32'h4);
    tick();
    chk("single_wenb",  32'(WEnb),      32'h1);
    chk("single_waddr", 32'(WAddr),     32'h2);
    chk("single_ptr",   32'(dut.ptr_q), 32'h3);
    req_valid = '0;
    tick();
    chk("idle_wenb",  32'(WEnb),     32'h0);
    chk("idle_waddr", 32'(WAddr),    32'h2);
    chk("idle_wdata", WData,         32'hA2);
    chk("idle_wcnt",  32'(wait_cnt), 32'd4);

    // Hold with two requesters after a fresh reset
    do_reset();
    hold      = 1'b1;
    req_valid = 4'b1010;
    #1;
    chk("hold_ready", 32'(req_ready), 32'h0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("hold_ready_c", 32'(req_ready), 32'h0);
      chk("hold_wenb",    32'(WEnb),      32'h0);
    end
    chk("hold_wcnt", 32'(wait_cnt),  32'd3);
    chk("hold_ptr",  32'(dut.ptr_q), 32'h0);
    hold = 1'b0;
    #1;
    chk("rel_ready1", 32'(req_ready), 32'h2);
    tick();
    chk("rel_waddr1", 32'(WAddr),     32'h1);
    chk("rel_ready3", 32'(req_ready), 32'h8);
    tick();
    chk("rel_waddr3", 32'(WAddr), 32'h3);
    chk("rel_wdata3", WData,      32'hA3);
    req_valid = '0;
    #1;

    // Wrap-around: ptr=3 with 1001 grants 3 then 0
    req_valid = 4'b0100;
    tick();
    chk("wrap_ptr3", 32'(dut.ptr_q), 32'h3);
    req_valid = 4'b1001;
    #1;
    chk("wrap_ready3", 32'(req_ready), 32'h8);
    tick();
    chk("wrap_waddr3", 32'(WAddr),     32'h3);
    chk("wrap_ptr0",   32'(dut.ptr_q), 32'h0);
    chk("wrap_ready0", 32'(req_ready), 32'h1);
    tick();
    chk("wrap_waddr0", 32'(WAddr), 32'h0);
    chk("wrap_wdata0", WData,      32'hA0);
    req_valid = '0;
    #1;

    // Reset arriving the cycle after a grant to requester 3
    req_valid = 4'b1000;
    #1;
    chk("rg_ready3", 32'(req_ready), 32'h8);
    tick();
    req_valid = '0;
    rst       = 1'b1;
    #1;
    chk("rg_wenb_pre",  32'(WEnb),      32'h1);
    chk("rg_waddr_pre", 32'(WAddr),     32'h3);
    chk("rg_ready_rst", 32'(req_ready), 32'h0);
    tick();
    chk("rg_wenb",  32'(WEnb),      32'h0);
    chk("rg_waddr", 32'(WAddr),     32'h0);
    chk("rg_ptr",   32'(dut.ptr_q), 32'h0);
    rst       = 1'b0;
    req_valid = 4'b1001;
    #1;
    chk("rg_ready0", 32'(req_ready), 32'h1);
    tick();
    chk("rg_waddr0", 32'(WAddr),     32'h0);
    chk("rg_ready_n", 32'(req_ready), 32'h8);
    tick();
    chk("rg_waddr3", 32'(WAddr), 32'h3);
    req_valid = '0;
    #1;

    // Saturation of the contention counter
    do_reset();
    hold      = 1'b1;
    req_valid = 4'b0011;
    for (int c = 0; c < 65534; c++) tick();
    chk("sat_fffe", 32'(wait_cnt), 32'hFFFE);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("sat_ffff", 32'(wait_cnt), 32'hFFFF);
    end
    hold      = 1'b0;
    req_valid = '0;
    tick();
    chk("sat_hold", 32'(wait_cnt), 32'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mrram_wr_arb.md
MRRAM_WR_ARB -- requirements
Module: mrram_wr_arb

Interface
REQ-001 The block SHALL have parameter MEMD, default 16, meaning register-file depth in words.
REQ-002 The block SHALL have parameter DATAW, default 32, meaning word width in bits.
REQ-003 The block SHALL have parameter nWREQ, default 4, meaning number of write requesters (range 2..8).
REQ-004 The block SHALL have localparam ADDRW = ceil(log2(MEMD)), meaning address width.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-007 The block SHALL have port hold, input, 1 bit, which suppresses all grants while high.
REQ-008 The block SHALL have port req_valid, input, nWREQ bits, the per-requester write request.
REQ-009 The block SHALL have port req_addr, input, nWREQ*ADDRW bits; requester i uses slice [i*ADDRW +: ADDRW].
REQ-010 The block SHALL have port req_data, input, nWREQ*DATAW bits; requester i uses slice [i*DATAW +: DATAW].
REQ-011 The block SHALL have port req_ready, output, nWREQ bits, a one-hot or zero grant.
REQ-012 The block SHALL have port WEnb, output, 1 bit, the registered write enable to the multi-read-port RAM.
REQ-013 The block SHALL have port WAddr, output, ADDRW bits, the registered write address.
REQ-014 The block SHALL have port WData, output, DATAW bits, the registered write data.
REQ-015 The block SHALL have port wait_cnt, output, 16 bits, a saturating contention counter.

Function
REQ-016 req_ready SHALL be combinational from req_valid, ptr, hold and rst, and SHALL have at most one bit set.
REQ-017 The grant SHALL go to the first i with req_valid[i]=1, searching ptr, ptr+1, … mod nWREQ.
REQ-018 req_ready SHALL be all-zero when hold=1, when rst=1, or when req_valid=0.
REQ-019 A transfer SHALL occur on requester i in any cycle where req_valid[i] and req_ready[i] are both 1.
REQ-020 A requester SHALL keep req_valid, req_addr and req_data stable until its transfer; the block does not latch unaccepted requests.
REQ-021 On a transfer in cycle N, cycle N+1 SHALL present WEnb=1 with WAddr and WData equal to the granted requester's slices (1-cycle latency).
REQ-022 With no transfer in cycle N, cycle N+1 SHALL present WEnb=0, and WAddr and WData SHALL hold their previous values.
REQ-023 On a transfer, ptr SHALL become (granted index + 1) mod nWREQ; otherwise ptr SHALL be unchanged, including while hold=1.
REQ-024 Throughput SHALL be one write per cycle; a continuously valid requester SHALL be granted within nWREQ cycles of hold being low.
REQ-025 Two requesters targeting the same address SHALL be serialized in grant order; the later write lands last, with no merging.
REQ-026 wait_cnt SHALL increment by 1 in each cycle where popcount(req_valid) >= 2 and rst=0, including during hold.
REQ-027 wait_cnt SHALL saturate at 16'hFFFF and never wrap.
REQ-028 When ptr wraps from nWREQ-1, it SHALL go to 0.

Reset
REQ-029 While rst=1, at the next edge ptr, WEnb, WAddr, WData and wait_cnt SHALL all become 0.
REQ-030 While rst=1, req_ready SHALL be 0, so no transfer occurs.
REQ-031 A transfer accepted in the cycle before rst asserts SHALL still appear on WEnb in the following cycle unless rst is high at that edge, in which case it SHALL be discarded.
REQ-032 The first cycle after rst deasserts SHALL grant normally from ptr=0.

Verification
REQ-033 Bench (nWREQ=4): after reset, req_valid=4'b1111 for 4 cycles with each requester i having addr=i and data=32'hA0+i -> grants in order 0,1,2,3; WEnb=1 on cycles 2..5 with WAddr 0,1,2,3; wait_cnt=4.
REQ-034 Bench: req_valid=4'b0100 only -> req_ready=4'b0100 in the same cycle, WEnb=1 and WAddr=2 next cycle, then ptr=3; in the following idle cycle WEnb=0 and WAddr stays 2.
REQ-035 Bench: hold=1 with req_valid=4'b1010 for 3 cycles -> req_ready=0, WEnb=0, wait_cnt=3; on hold release requester 1 is granted first.
REQ-036 Bench: force wait_cnt to 16'hFFFE and keep 2 requesters valid for 3 cycles -> wait_cnt reads FFFF and holds there.
REQ-037 Bench: rst asserted in the cycle after a grant to requester 3 -> WEnb=0, WAddr=0, ptr=0; after release, req_valid=4'b1001 grants requester 0 first.
REQ-038 Bench: ptr=3 with req_valid=4'b1001 -> requester 3 is granted, then requester 0 (wrap-around check).
